// File: rtl/uart_rx_fifo.sv
// Receive-side 8N1 UART: 2-FF synchroniser, start/data/stop FSM and a small byte FIFO
// with registered head, framing-error and overrun pulses.
module uart_rx_fifo #(
    parameter int unsigned clk_freq       = 50000000,
    parameter int unsigned uart_baud_rate = 115200,
    parameter int unsigned fifo_depth     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_avail,
    input  logic                          rx_ack,
    output logic [$clog2(fifo_depth):0]   rx_level,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int unsigned BIT_CYCLES  = clk_freq / uart_baud_rate;
    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam int unsigned CW          = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned PW          = $clog2(fifo_depth);

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [PW:0]   FULL_LEVEL = (PW + 1)'(fifo_depth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            rx_meta;
    logic            rxs;

    logic [7:0]      mem [fifo_depth];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_next;
    logic [7:0]      head_next;
    logic            push;
    logic            pop;
    logic            full;
    logic            do_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Push is decided on the stop-sample edge itself; the head register bypasses
    // the array when the FIFO would otherwise be empty after this cycle's pop.
    always_comb begin
        push      = (state == S_STOP) && (cnt == BIT_LAST) && rxs;
        pop       = rx_ack && (rx_level != '0);
        full      = (rx_level == FULL_LEVEL);
        do_push   = push && (!full || pop);
        rd_next   = rd_ptr + PW'(pop);
        head_next = (do_push && (rx_level == (PW + 1)'(pop))) ? shreg : mem[rd_next];
        rx_avail  = (rx_level != '0);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_level <= '0;
            rx_data  <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            rd_ptr  <= rd_next;
            rx_data <= head_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: rx_level <= rx_level;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 50 MHz / 115200 baud with a 4-entry FIFO.
module tb_uart_rx_fifo;

    localparam int BIT     = 434;
    localparam int HALF    = 217;
    // pin drive after edge 0 -> 2 sync edges -> IDLE sees low on edge 3
    localparam int STOP_AT = 3 + HALF + 9 * BIT;
    localparam int FRAME   = 10 * BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic [2:0] rx_level;
    logic       frame_err;
    logic       overrun;

    int nvec = 0;
    int nerr = 0;

    uart_rx_fifo #(
        .clk_freq      (50000000),
        .uart_baud_rate(115200),
        .fifo_depth    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_ack   (rx_ack),
        .rx_level (rx_level),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #10 clk = ~clk;

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int ack_at,
                               input int n_cyc, output int fe, output int ov);
        int k;
        fe = 0;
        ov = 0;
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk);
            #1;
            if (frame_err) fe++;
            if (overrun) ov++;
            k = c / BIT;
            if (k == 0) uart_rxd = 1'b0;
            else if (k <= 8) uart_rxd = b[k-1];
            else uart_rxd = stop_bit;
            rx_ack = (c == ack_at);
        end
        rx_ack = 1'b0;
    endtask

    task automatic hold_line(input logic lvl, input int n, output int fe, output int ov);
        fe = 0;
        ov = 0;
        uart_rxd = lvl;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (frame_err) fe++;
            if (overrun) ov++;
        end
    endtask

    task automatic pop_byte;
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    task automatic test_reset;
        #5 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({rx_avail, rx_level, rx_data, frame_err, overrun} !== 14'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got avail=%b level=%0d data=%h fe=%b ov=%b, want all 0",
                     rx_avail, rx_level, rx_data, frame_err, overrun);
        end
        rst = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_basic;
        int fe, ov;
        drive_frame(8'h55, 1'b1, -1, FRAME, fe, ov);
        nvec++;
        if (rx_level !== 3'd1 || rx_avail !== 1'b1 || rx_data !== 8'h55) begin
            nerr++;
            $display("FAIL basic_first: level=%0d avail=%b data=%h, want 1 1 55", rx_level, rx_avail, rx_data);
        end
        drive_frame(8'hA3, 1'b1, -1, FRAME, fe, ov);
        nvec++;
        if (rx_level !== 3'd2 || rx_data !== 8'h55 || fe !== 0 || ov !== 0) begin
            nerr++;
            $display("FAIL basic_second: level=%0d data=%h fe=%0d ov=%0d, want 2 55 0 0", rx_level, rx_data, fe, ov);
        end
        pop_byte();
        nvec++;
        if (rx_data !== 8'hA3 || rx_level !== 3'd1) begin
            nerr++;
            $display("FAIL basic_pop1: data=%h level=%0d, want a3 1", rx_data, rx_level);
        end
        pop_byte();
        nvec++;
        if (rx_avail !== 1'b0 || rx_level !== 3'd0) begin
            nerr++;
            $display("FAIL basic_pop2: avail=%b level=%0d, want 0 0", rx_avail, rx_level);
        end
    endtask

    task automatic test_glitch;
        int fe0, ov0, fe1, ov1;
        hold_line(1'b0, 100, fe0, ov0);
        hold_line(1'b1, 500, fe1, ov1);
        nvec++;
        if (rx_level !== 3'd0 || rx_avail !== 1'b0 || (fe0 + fe1) !== 0 || (ov0 + ov1) !== 0) begin
            nerr++;
            $display("FAIL glitch: level=%0d avail=%b fe=%0d ov=%0d, want 0 0 0 0",
                     rx_level, rx_avail, fe0 + fe1, ov0 + ov1);
        end
    endtask

    task automatic test_frame_err;
        int fe0, ov0, fe1, ov1, fe2, ov2;
        drive_frame(8'h3C, 1'b0, -1, FRAME, fe0, ov0);
        hold_line(1'b0, 3 * BIT, fe1, ov1);
        hold_line(1'b1, 50, fe2, ov2);
        nvec++;
        if ((fe0 + fe1 + fe2) !== 1 || rx_level !== 3'd0 || (ov0 + ov1 + ov2) !== 0) begin
            nerr++;
            $display("FAIL frame_err_pulse: fe=%0d level=%0d ov=%0d, want 1 0 0",
                     fe0 + fe1 + fe2, rx_level, ov0 + ov1 + ov2);
        end
        drive_frame(8'h01, 1'b1, -1, FRAME, fe0, ov0);
        nvec++;
        if (rx_level !== 3'd1 || rx_data !== 8'h01 || fe0 !== 0) begin
            nerr++;
            $display("FAIL frame_err_recover: level=%0d data=%h fe=%0d, want 1 01 0", rx_level, rx_data, fe0);
        end
        pop_byte();
        nvec++;
        if (rx_avail !== 1'b0) begin
            nerr++;
            $display("FAIL frame_err_drain: avail=%b, want 0", rx_avail);
        end
    endtask

    task automatic test_overrun;
        int fe, ov;
        for (int i = 0; i < 5; i++) begin
            drive_frame(8'h10 + 8'(i), 1'b1, -1, FRAME, fe, ov);
            nvec++;
            if (ov !== ((i == 4) ? 1 : 0) || fe !== 0) begin
                nerr++;
                $display("FAIL overrun_frame%0d: ov=%0d fe=%0d, want %0d 0", i, ov, fe, (i == 4) ? 1 : 0);
            end
        end
        nvec++;
        if (rx_level !== 3'd4 || rx_avail !== 1'b1 || rx_data !== 8'h10) begin
            nerr++;
            $display("FAIL overrun_state: level=%0d avail=%b data=%h, want 4 1 10", rx_level, rx_avail, rx_data);
        end
    endtask

    task automatic test_full_ack;
        int fe, ov;
        logic [7:0] exp_q [4];
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h99};
        drive_frame(8'h99, 1'b1, STOP_AT - 1, FRAME, fe, ov);
        nvec++;
        if (ov !== 0 || rx_level !== 3'd4 || rx_data !== 8'h11) begin
            nerr++;
            $display("FAIL full_ack: ov=%0d level=%0d data=%h, want 0 4 11", ov, rx_level, rx_data);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (rx_data !== exp_q[i] || rx_avail !== 1'b1) begin
                nerr++;
                $display("FAIL full_ack_pop%0d: data=%h avail=%b, want %h 1", i, rx_data, rx_avail, exp_q[i]);
            end
            pop_byte();
        end
        nvec++;
        if (rx_avail !== 1'b0 || rx_level !== 3'd0) begin
            nerr++;
            $display("FAIL full_ack_drain: avail=%b level=%0d, want 0 0", rx_avail, rx_level);
        end
    endtask

    task automatic test_reset_midframe;
        int fe0, ov0, fe1, ov1;
        drive_frame(8'h5A, 1'b1, -1, FRAME, fe0, ov0);
        drive_frame(8'h00, 1'b1, -1, 5 * BIT + 200, fe0, ov0);
        rst = 1'b0;
        uart_rxd = 1'b1;
        #2;
        nvec++;
        if ({rx_avail, rx_level, rx_data, frame_err, overrun} !== 14'h0) begin
            nerr++;
            $display("FAIL midframe_reset: avail=%b level=%0d data=%h fe=%b ov=%b, want all 0",
                     rx_avail, rx_level, rx_data, frame_err, overrun);
        end
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        hold_line(1'b1, 20, fe1, ov1);
        drive_frame(8'hE7, 1'b1, -1, FRAME, fe0, ov0);
        nvec++;
        if (rx_level !== 3'd1 || rx_data !== 8'hE7 || (fe0 + fe1) !== 0 || (ov0 + ov1) !== 0) begin
            nerr++;
            $display("FAIL midframe_next: level=%0d data=%h fe=%0d ov=%0d, want 1 e7 0 0",
                     rx_level, rx_data, fe0 + fe1, ov0 + ov1);
        end
        pop_byte();
        nvec++;
        if (rx_avail !== 1'b0) begin
            nerr++;
            $display("FAIL midframe_only_one: avail=%b, want 0", rx_avail);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_ack();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
